// File: rtl/rf_multiport.sv
// rf_multiport: integer register file with NRD combinational read ports, one bypassed
// synchronous write port, a per-entry busy scoreboard and a one-entry-per-cycle clear engine.
module rf_multiport #(
    parameter int  XLEN     = 32,
    parameter int  NREG     = 32,
    parameter int  NRD      = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NRD*AW-1:0]   ra_i,
    output logic [NRD*XLEN-1:0] rd_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                we_i,
    input  logic [AW-1:0]       wa_i,
    input  logic [XLEN-1:0]     wd_i,
    input  logic                alloc_i,
    input  logic [AW-1:0]       alloc_addr_i,
    input  logic                clr_req_i,
    output logic                clr_busy_o,
    output logic                clr_done_o
);
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            clr_done_q, clr_done_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic [XLEN-1:0] mem_q [NREG];
    logic            zero_en_s, idle_s, we_eff_s, alloc_eff_s;

    assign zero_en_s   = (ZERO_REG != 0);
    assign idle_s      = (state_q == IDLE);
    // A clear request in IDLE swallows any write or allocate presented alongside it.
    assign we_eff_s    = we_i & idle_s & ~clr_req_i & ~(zero_en_s & (wa_i == '0));
    assign alloc_eff_s = alloc_i & idle_s & ~clr_req_i & ~(zero_en_s & (alloc_addr_i == '0));
    assign clr_busy_o  = (state_q == CLEAR);
    assign clr_done_o  = clr_done_q;

    // Clear-engine next state: walk idx over every entry, then fall back to IDLE.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        clr_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = CLEAR;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                idx_d = idx_q + AW'(1);
                if (idx_q == AW'(NREG - 1)) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end else begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Scoreboard next state: release on write, then allocate so a same-address alloc wins.
    always_comb begin
        busy_d = busy_q;
        if (idle_s && clr_req_i) begin
            busy_d = '0;
        end else begin
            busy_d[wa_i]         = busy_q[wa_i] & ~we_eff_s;
            busy_d[alloc_addr_i] = busy_d[alloc_addr_i] | alloc_eff_s;
        end
    end

    // Control and scoreboard registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= CLEAR;
            idx_q      <= '0;
            clr_done_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            clr_done_q <= clr_done_d;
            busy_q     <= busy_d;
        end
    end

    // Storage array: zeroed by the clear engine, otherwise written by the write port.
    always_ff @(posedge clk_i) begin
        if (state_q == CLEAR) begin
            mem_q[idx_q] <= '0;
        end else if (we_eff_s) begin
            mem_q[wa_i] <= wd_i;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] ra_s;
        logic          hit_s;
        logic          zero_s;

        assign ra_s   = ra_i[g*AW +: AW];
        assign hit_s  = we_eff_s & (wa_i == ra_s);
        assign zero_s = clr_busy_o | (zero_en_s & (ra_s == '0));
        assign rd_o[g*XLEN +: XLEN] = zero_s ? '0 : (hit_s ? wd_i : mem_q[ra_s]);
        assign rd_busy_o[g]         = ~zero_s & ~hit_s & busy_q[ra_s];
    end
endmodule

// File: doc/rf_multiport.md
# rf_multiport

Parametrised integer register file for the pipelined core: NRD combinational read ports, one synchronous write port with write-to-read bypass, and an optional hard-wired zero register. Each entry has a busy bit for decode-stage hazard detection. A sequential clear engine zeroes the array one entry per cycle after reset or on request. Sits between decode (reads, busy query, destination allocate) and writeback (write port).

## Interface
- XLEN, 32, data width in bits.
- NREG, 32, number of entries; power of two, at least 2. AW = clog2(NREG).
- NRD, 2, number of read ports, at least 1.
- ZERO_REG, 1, if 1 then entry 0 reads 0, is never written and is never busy.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ra  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN].
- rd_busy  out  NRD  port i's entry has a pending write.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- alloc  in  1  mark entry alloc_addr as busy.
- alloc_addr  in  AW  entry to allocate.
- clr_req  in  1  start a full clear (single-cycle pulse).
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse on clear completion.

## Operation
- FSM states IDLE and CLEAR, with an AW-bit index register idx.
- While rst is low: state=CLEAR, idx=0, all busy bits 0, clr_done=0. Array contents are not reset directly.
- CLEAR: each cycle write 0 to entry idx, then idx++.
  - When idx==NREG-1, that write occurs and state goes to IDLE on the same edge.
  - clr_done is 1 for the first IDLE cycle only.
- IDLE with clr_req=1: go to CLEAR with idx=0 and clear all busy bits.
  - A we or alloc in that same cycle is dropped.
  - clr_req during CLEAR is ignored; the clear is not restarted.
- clr_busy = (state==CLEAR). It is combinational from state, so it is 1 during reset.
- Effective write: we_eff = we & IDLE & ~clr_req & ~(ZERO_REG & wa==0).
  - When we_eff=1, entry wa takes wd at the clock edge.
  - Writes during CLEAR are dropped. The producer must hold off until clr_busy=0.
- Read port i (combinational):
  - During CLEAR: 0.
  - ZERO_REG and ra_i==0: 0.
  - we_eff and wa==ra_i: wd (write-first bypass).
  - Otherwise: the stored entry.
- Scoreboard, updated at the clock edge in IDLE:
  - we_eff clears busy[wa].
  - alloc (when not dropped) sets busy[alloc_addr].
  - alloc and write to the same address in one cycle: set wins, and the entry ends busy.
  - If ZERO_REG, alloc to entry 0 is ignored.
- rd_busy[i] = busy[ra_i] & ~(we_eff & wa==ra_i). It is 0 during CLEAR and 0 for entry 0 when ZERO_REG.

## Timing
- Read data and rd_busy have zero latency: combinational from ra, we, wa and wd.
- Write to read of the same address takes 0 cycles via bypass, or 1 cycle via the array.
- Alloc to rd_busy=1 takes 1 cycle.
- A clear occupies exactly NREG cycles with clr_busy=1.
  - After rst rises, or after clr_req is sampled, the first accepted write is in cycle NREG.
  - clr_done rises in cycle NREG.
- Reset mid-clear or mid-operation: asynchronous return to CLEAR with idx=0, and the full NREG-cycle clear restarts after release.
- Reset values: clr_busy=1, clr_done=0, rd=0, rd_busy=0.

## Test plan
- Reset release, NREG=32: clr_busy stays 1 for 32 cycles, then clr_done pulses once; every port then reads 0 at all addresses; no write lands while clr_busy=1.
- Write and read: write 0xDEADBEEF to reg 5 with ra0=5 in the same cycle -> rd0=0xDEADBEEF (bypass) and it persists next cycle; writing reg 0 -> reads 0 when ZERO_REG=1, and reads back the data when ZERO_REG=0.
- Scoreboard: alloc reg 7 -> rd_busy for ra=7 is 1 next cycle; write reg 7 -> rd_busy=0 in that same cycle, busy bit clear afterwards. Alloc and write to reg 9 in the same cycle -> reg 9 busy next cycle, holding the written data.
- clr_req with we=1 to reg 3 (value 0x1234) in the same cycle -> write dropped, all busy bits cleared, 32-cycle clear runs, reg 3 reads 0 afterwards; a second clr_req mid-clear does not extend it.
- Reset asserted at idx=10 mid-clear -> clr_busy stays 1 and the full 32-cycle clear restarts from entry 0; random prior contents all read 0 afterwards.
- NRD=3, XLEN=16, NREG=8: three ports read distinct regs simultaneously with correct data; wrap case idx=7 completes the clear in 8 cycles.
